// File: rtl/cajero_automatico_param.sv
// ATM session controller: parametrised PIN capture with attempt lockout,
// followed by deposit/withdrawal transactions against a session balance.
module cajero_automatico_param #(
  parameter int unsigned PIN_DIGITS     = 4,
  parameter int unsigned MAX_INTENTOS   = 3,
  parameter int unsigned MONTO_W        = 32,
  parameter int unsigned BALANCE_W      = 64,
  parameter int unsigned LIMITE_RETIRO  = 500,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tarjeta_recibida,
  input  logic                                digito_stb,
  input  logic [3:0]                          digito,
  input  logic [4*PIN_DIGITS-1:0]             pin_correcto,
  input  logic                                cancelar,
  input  logic                                trans_stb,
  input  logic                                tipo_trans,
  input  logic [MONTO_W-1:0]                  monto,
  input  logic [BALANCE_W-1:0]                balance_inicial,
  output logic                                pin_incorrecto,
  output logic                                advertencia,
  output logic                                bloqueo,
  output logic [$clog2(MAX_INTENTOS+1)-1:0]   intentos_fallidos,
  output logic [BALANCE_W-1:0]                balance_actualizado,
  output logic                                balance_stb,
  output logic                                entregar_dinero,
  output logic                                fondos_insuficientes,
  output logic                                limite_excedido,
  output logic                                error_desborde,
  output logic                                timeout
);

  localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
  localparam int unsigned CNT_W  = $clog2(PIN_DIGITS + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CICLOS + 1);
  localparam int unsigned RET_W  = MONTO_W + 1;
  localparam int unsigned CMP_W  = (MONTO_W > BALANCE_W) ? MONTO_W : BALANCE_W;
  localparam int unsigned SUM_W  = CMP_W + 1;

  typedef enum logic [2:0] {IDLE, PIN, VERIFICAR, TRANSACCION, BLOQUEO} estado_t;

  estado_t              state_q, state_d;
  logic [PIN_W-1:0]     pin_buf_q, pin_buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [FAIL_W-1:0]    fails_q, fails_d;
  logic [BALANCE_W-1:0] saldo_q, saldo_d;
  logic [MONTO_W-1:0]   ret_q, ret_d;
  logic                 pin_inc_d, bstb_d, disp_d, fondos_d, lim_d, ovf_d, to_d;
  logic                 activity, expira, insuf, exced, desborde;
  logic [RET_W-1:0]     ret_sum;
  logic [SUM_W-1:0]     dep_sum;

  assign balance_actualizado = saldo_q;
  assign intentos_fallidos   = fails_q;

  // Next-state, session bookkeeping and transaction evaluation
  always_comb begin
    state_d   = state_q;
    pin_buf_d = pin_buf_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    fails_d   = fails_q;
    saldo_d   = saldo_q;
    ret_d     = ret_q;
    pin_inc_d = 1'b0;
    bstb_d    = 1'b0;
    disp_d    = 1'b0;
    fondos_d  = 1'b0;
    lim_d     = 1'b0;
    ovf_d     = 1'b0;
    to_d      = 1'b0;

    activity = digito_stb | trans_stb;
    expira   = !activity && (tmr_q == TMR_W'(TIMEOUT_CICLOS - 1));
    ret_sum  = RET_W'(ret_q) + RET_W'(monto);
    exced    = ret_sum > RET_W'(LIMITE_RETIRO);
    insuf    = CMP_W'(monto) > CMP_W'(saldo_q);
    dep_sum  = SUM_W'(saldo_q) + SUM_W'(monto);
    desborde = |dep_sum[SUM_W-1:BALANCE_W];

    case (state_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          state_d = PIN;
          tmr_d   = '0;
        end
      end
      PIN, VERIFICAR, TRANSACCION: begin
        if (!tarjeta_recibida || cancelar || (state_q != VERIFICAR && expira)) begin
          // Abort: timeout pulse only when neither card removal nor cancel caused it
          to_d      = tarjeta_recibida && !cancelar;
          state_d   = IDLE;
          pin_buf_d = '0;
          cnt_d     = '0;
          tmr_d     = '0;
        end else if (state_q == PIN) begin
          tmr_d = activity ? '0 : tmr_q + TMR_W'(1);
          if (digito_stb) begin
            pin_buf_d = PIN_W'({pin_buf_q, digito});
            if (cnt_q == CNT_W'(PIN_DIGITS - 1)) begin
              state_d = VERIFICAR;
              cnt_d   = '0;
              tmr_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else if (state_q == VERIFICAR) begin
          tmr_d     = '0;
          cnt_d     = '0;
          pin_buf_d = '0;
          if (pin_buf_q == pin_correcto) begin
            state_d = TRANSACCION;
            fails_d = '0;
            saldo_d = balance_inicial;
            ret_d   = '0;
            bstb_d  = 1'b1;
          end else begin
            pin_inc_d = 1'b1;
            fails_d   = fails_q + FAIL_W'(1);
            state_d   = (fails_q == FAIL_W'(MAX_INTENTOS - 1)) ? BLOQUEO : PIN;
          end
        end else begin
          tmr_d = activity ? '0 : tmr_q + TMR_W'(1);
          if (trans_stb) begin
            if (tipo_trans) begin
              fondos_d = insuf;
              lim_d    = exced;
              if (!insuf && !exced) begin
                saldo_d = saldo_q - BALANCE_W'(monto);
                ret_d   = MONTO_W'(ret_sum);
                bstb_d  = 1'b1;
                disp_d  = 1'b1;
              end
            end else if (desborde) begin
              ovf_d = 1'b1;
            end else begin
              saldo_d = BALANCE_W'(dep_sum);
              bstb_d  = 1'b1;
            end
          end
        end
      end
      BLOQUEO: begin
        state_d = BLOQUEO;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= IDLE;
      pin_buf_q            <= '0;
      cnt_q                <= '0;
      tmr_q                <= '0;
      fails_q              <= '0;
      saldo_q              <= '0;
      ret_q                <= '0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      limite_excedido      <= 1'b0;
      error_desborde       <= 1'b0;
      timeout              <= 1'b0;
    end else begin
      state_q              <= state_d;
      pin_buf_q            <= pin_buf_d;
      cnt_q                <= cnt_d;
      tmr_q                <= tmr_d;
      fails_q              <= fails_d;
      saldo_q              <= saldo_d;
      ret_q                <= ret_d;
      pin_incorrecto       <= pin_inc_d;
      advertencia          <= (fails_d == FAIL_W'(MAX_INTENTOS - 1));
      bloqueo              <= (state_d == BLOQUEO);
      balance_stb          <= bstb_d;
      entregar_dinero      <= disp_d;
      fondos_insuficientes <= fondos_d;
      limite_excedido      <= lim_d;
      error_desborde       <= ovf_d;
      timeout              <= to_d;
    end
  end

endmodule

// File: tb/tb_cajero_automatico_param.sv
// Bench for cajero_automatico_param: directed session scenarios plus random
// traffic, checked every cycle against a session-level behavioural model.
module tb_cajero_automatico_param;

  localparam int unsigned PD    = 4;
  localparam int unsigned MAXI  = 3;
  localparam int unsigned LIMIT = 500;
  localparam int unsigned TOUT  = 40;

  localparam int M_IDLE = 0, M_PIN = 1, M_VER = 2, M_TRANS = 3, M_LOCK = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        card, dstb, cancel, tstb, tipo;
  logic [3:0]  digit;
  logic [15:0] pin;
  logic [31:0] monto;
  logic [63:0] bal_ini;

  logic        pin_inc, adv, blk, bstb, disp, fondos, lim, ovf, to;
  logic [1:0]  fails;
  logic [63:0] bal;

  int checks = 0;
  int errors = 0;

  cajero_automatico_param #(
    .PIN_DIGITS(PD), .MAX_INTENTOS(MAXI), .MONTO_W(32), .BALANCE_W(64),
    .LIMITE_RETIRO(LIMIT), .TIMEOUT_CICLOS(TOUT)
  ) dut (
    .clk(clk), .reset(reset_n), .tarjeta_recibida(card), .digito_stb(dstb),
    .digito(digit), .pin_correcto(pin), .cancelar(cancel), .trans_stb(tstb),
    .tipo_trans(tipo), .monto(monto), .balance_inicial(bal_ini),
    .pin_incorrecto(pin_inc), .advertencia(adv), .bloqueo(blk),
    .intentos_fallidos(fails), .balance_actualizado(bal), .balance_stb(bstb),
    .entregar_dinero(disp), .fondos_insuficientes(fondos), .limite_excedido(lim),
    .error_desborde(ovf), .timeout(to)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_phase = M_IDLE;
  int          m_digits[$];
  int          m_timer = 0;
  int          m_fails = 0;
  logic [64:0] m_saldo = '0;
  longint unsigned m_withdrawn = 0;
  logic        e_pin_inc = 0, e_adv = 0, e_blk = 0, e_bstb = 0, e_disp = 0;
  logic        e_fondos = 0, e_lim = 0, e_ovf = 0, e_to = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the session rules
  task automatic model_step();
    bit activity, expired;
    longint unsigned v;
    logic [64:0] sum;
    e_pin_inc = 0; e_bstb = 0; e_disp = 0; e_fondos = 0; e_lim = 0; e_ovf = 0; e_to = 0;
    if (!reset_n) begin
      m_phase = M_IDLE; m_digits.delete(); m_timer = 0; m_fails = 0;
      m_saldo = '0; m_withdrawn = 0;
    end else if (m_phase == M_IDLE) begin
      if (card) begin m_phase = M_PIN; m_timer = 0; end
    end else if (m_phase != M_LOCK) begin
      activity = dstb || tstb;
      expired  = (m_phase != M_VER) && !activity && (m_timer + 1 >= int'(TOUT));
      if (!card || cancel || expired) begin
        e_to = card && !cancel;
        m_phase = M_IDLE; m_digits.delete(); m_timer = 0;
      end else if (m_phase == M_PIN) begin
        m_timer = activity ? 0 : m_timer + 1;
        if (dstb) begin
          m_digits.push_back(int'(digit));
          if (m_digits.size() == int'(PD)) begin m_phase = M_VER; m_timer = 0; end
        end
      end else if (m_phase == M_VER) begin
        v = 0;
        foreach (m_digits[i]) v = v * 16 + longint'(m_digits[i]);
        m_digits.delete(); m_timer = 0;
        if (v == longint'(pin)) begin
          m_phase = M_TRANS; m_fails = 0; m_saldo = {1'b0, bal_ini};
          m_withdrawn = 0; e_bstb = 1;
        end else begin
          m_fails++; e_pin_inc = 1;
          m_phase = (m_fails == int'(MAXI)) ? M_LOCK : M_PIN;
        end
      end else begin
        m_timer = activity ? 0 : m_timer + 1;
        if (tstb) begin
          if (tipo) begin
            e_fondos = (65'(monto) > m_saldo);
            e_lim    = (m_withdrawn + longint'(monto) > longint'(LIMIT));
            if (!e_fondos && !e_lim) begin
              m_saldo = m_saldo - 65'(monto);
              m_withdrawn = m_withdrawn + longint'(monto);
              e_bstb = 1; e_disp = 1;
            end
          end else begin
            sum = m_saldo + 65'(monto);
            if (sum[64]) e_ovf = 1;
            else begin m_saldo = sum; e_bstb = 1; end
          end
        end
      end
    end
    e_adv = (m_fails == int'(MAXI) - 1);
    e_blk = (m_phase == M_LOCK);
  endtask

  // Model update on every edge, full output compare just after it
  always @(posedge clk) begin
    model_step();
    #1;
    check("pin_incorrecto", 64'(pin_inc), 64'(e_pin_inc));
    check("advertencia", 64'(adv), 64'(e_adv));
    check("bloqueo", 64'(blk), 64'(e_blk));
    check("intentos_fallidos", 64'(fails), 64'(m_fails));
    check("balance_actualizado", bal, m_saldo[63:0]);
    check("balance_stb", 64'(bstb), 64'(e_bstb));
    check("entregar_dinero", 64'(disp), 64'(e_disp));
    check("fondos_insuficientes", 64'(fondos), 64'(e_fondos));
    check("limite_excedido", 64'(lim), 64'(e_lim));
    check("error_desborde", 64'(ovf), 64'(e_ovf));
    check("timeout", 64'(to), 64'(e_to));
  end

  task automatic send_digits(input logic [15:0] p, input int n);
    logic [15:0] v;
    v = p;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dstb = 1'b1;
      digit = v[4*(n-1-i) +: 4];
    end
    @(negedge clk);
    dstb = 1'b0;
  endtask

  task automatic send_trans(input logic t, input logic [31:0] m);
    @(negedge clk);
    tstb = 1'b1; tipo = t; monto = m;
    @(negedge clk);
    tstb = 1'b0;
  endtask

  task automatic new_session();
    @(negedge clk); card = 1'b0;
    @(negedge clk); card = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    int quiet;
    logic [15:0] pv;
    quiet = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c % 200 == 0) quiet = ($urandom_range(0, 2) == 0) ? 1 : 0;
      reset_n = ($urandom_range(0, 999) < ((m_phase == M_LOCK) ? 15 : 2)) ? 1'b0 : 1'b1;
      card    = ($urandom_range(0, 99) < 98) ? 1'b1 : 1'b0;
      cancel  = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      if (m_phase == M_IDLE && $urandom_range(0, 19) == 0) pin = 16'($urandom);
      dstb = ($urandom_range(0, 99) < (quiet ? 1 : 45)) ? 1'b1 : 1'b0;
      pv = pin;
      if (m_digits.size() < int'(PD) && $urandom_range(0, 9) < 9)
        digit = pv[4*(int'(PD)-1-m_digits.size()) +: 4];
      else
        digit = 4'($urandom);
      tstb = ($urandom_range(0, 99) < (quiet ? 1 : 35)) ? 1'b1 : 1'b0;
      tipo = 1'($urandom);
      case ($urandom_range(0, 3))
        0: monto = $urandom_range(0, 300);
        1: monto = $urandom_range(0, 2000);
        2: monto = $urandom;
        default: monto = $urandom_range(0, 120);
      endcase
      case ($urandom_range(0, 3))
        0: bal_ini = 64'd1000;
        1: bal_ini = 64'($urandom_range(0, 5000));
        2: bal_ini = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3000));
        default: bal_ini = {$urandom, $urandom};
      endcase
    end
    @(negedge clk);
    reset_n = 1'b1; dstb = 1'b0; tstb = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; card = 1'b0; dstb = 1'b0; cancel = 1'b0; tstb = 1'b0;
    tipo = 1'b0; digit = '0; pin = 16'h3257; monto = '0; bal_ini = 64'd1000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_balance", bal, 64'd0);
    check("reset_bloqueo", 64'(blk), 64'd0);
    check("reset_intentos", 64'(fails), 64'd0);

    // Correct PIN, then deposit and withdraw
    card = 1'b1;
    @(negedge clk);
    send_digits(16'h3257, 4);
    @(negedge clk);
    check("pin_ok_balance", bal, 64'd1000);
    check("pin_ok_stb", 64'(bstb), 64'd1);
    check("pin_ok_no_incorrecto", 64'(pin_inc), 64'd0);
    send_trans(1'b0, 32'd100);
    check("dep100_balance", bal, 64'd1100);
    check("dep100_stb", 64'(bstb), 64'd1);
    send_trans(1'b1, 32'd50);
    check("wd50_balance", bal, 64'd1050);
    check("wd50_dispense", 64'(disp), 64'd1);

    // Cancel, new session: insufficient funds and withdrawal cap
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    send_digits(16'h3257, 4);
    @(negedge clk);
    check("s2_balance", bal, 64'd1000);
    send_trans(1'b1, 32'd2000);
    check("wd2000_fondos", 64'(fondos), 64'd1);
    check("wd2000_limite", 64'(lim), 64'd1);
    check("wd2000_balance", bal, 64'd1000);
    send_trans(1'b1, 32'd400);
    check("wd400a_balance", bal, 64'd600);
    send_trans(1'b1, 32'd400);
    check("wd400b_limite", 64'(lim), 64'd1);
    check("wd400b_fondos", 64'(fondos), 64'd0);
    check("wd400b_balance", bal, 64'd600);

    // Deposit overflow
    bal_ini = 64'hFFFF_FFFF_FFFF_FFF6;
    new_session();
    send_digits(16'h3257, 4);
    @(negedge clk);
    send_trans(1'b0, 32'd20);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_balance", bal, 64'hFFFF_FFFF_FFFF_FFF6);

    // Three wrong PINs lead to lockout
    new_session();
    for (int k = 1; k <= 3; k++) begin
      send_digits(16'h5555, 4);
      @(negedge clk);
      check("wrong_pulse", 64'(pin_inc), 64'd1);
      check("wrong_count", 64'(fails), 64'(k));
      check("wrong_adv", 64'(adv), (k == 2) ? 64'd1 : 64'd0);
      check("wrong_lock", 64'(blk), (k == 3) ? 64'd1 : 64'd0);
    end
    new_session();
    send_digits(16'h3257, 4);
    @(negedge clk);
    check("locked_stays", 64'(blk), 64'd1);
    check("locked_balance", bal, 64'hFFFF_FFFF_FFFF_FFF6);

    // Asynchronous reset clears lockout immediately
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("async_bloqueo", 64'(blk), 64'd0);
    check("async_intentos", 64'(fails), 64'd0);
    check("async_balance", bal, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Inactivity timeout mid-PIN, then a full PIN must still work
    bal_ini = 64'd1000;
    @(negedge clk);
    send_digits(16'h0032, 2);
    repeat (TOUT - 1) @(negedge clk);
    check("timeout_early", 64'(to), 64'd0);
    @(negedge clk);
    check("timeout_pulse", 64'(to), 64'd1);
    send_digits(16'h3257, 4);
    @(negedge clk);
    check("after_timeout_balance", bal, 64'd1000);
    check("after_timeout_stb", 64'(bstb), 64'd1);

    // Card removed in the same cycle as a digit
    new_session();
    send_digits(16'h0003, 1);
    card = 1'b0; dstb = 1'b1; digit = 4'h2;
    @(negedge clk);
    card = 1'b1; dstb = 1'b0;
    @(negedge clk);
    send_digits(16'h3257, 4);
    @(negedge clk);
    check("card_drop_resume", 64'(bstb), 64'd1);
    check("card_drop_timeout", 64'(to), 64'd0);

    random_phase(9000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
